dcache_snoop_agent: RTL and testbench
=====================================

// Module: dcache_snoop_agent
// PURPOSE
//  Cache-side coherence responder in each core's dcache; the opposite end of the two-cache MSI bus controller.
//  Probes the local frames with ccsnoopaddr while ccwait is high and raises cctrans on a dirty (M) hit.
//  Sources the two-word block writeback the controller forwards to memory, then downgrades M->S or invalidates on ccinv.
//  Clears the LL/SC link register on invalidation, and stalls the dcache's own miss/flush FSM while a snoop is serviced.
// PARAMETERS
//  IDX_W   3   set index width (8 sets)
//  TAG_W   26  tag width; addr = {tag[31:6], idx[5:3], blkoff[2], byteoff[1:0]}
//  WAYS    2   associativity; way 0 wins if both ways match (illegal state)
// PORTS
//  CLK           in   1     clock, rising edge
//  nRST          in   1     asynchronous reset, active low
//  ccwait        in   1     controller: other core owns bus, snoop this cache
//  ccinv         in   1     controller: invalidate block at ccsnoopaddr
//  ccsnoopaddr   in   32    snooped byte address
//  dwait         in   1     controller: current writeback word not yet accepted (active high)
//  probe_idx     out  IDX_W set index presented to frame array (comb)
//  frm_valid     in   WAYS  valid bits of probed set
//  frm_dirty     in   WAYS  dirty bits of probed set
//  frm_tag       in   WAYS*TAG_W tags of probed set
//  frm_data      in   WAYS*64 block data of probed set, word0 in [31:0]
//  upd_en        out  1     one-cycle frame state update strobe
//  upd_way       out  1     way to update
//  upd_valid     out  1     new valid bit
//  upd_dirty     out  1     new dirty bit
//  cctrans       out  1     snoop hit on dirty block; writeback follows
//  snp_daddr     out  32    writeback word address (parent muxes onto ccif_daddr)
//  snp_dstore    out  32    writeback word data (parent muxes onto ccif_dstore)
//  link_valid    in   1     LL link register valid
//  link_addr     in   32    LL link register address
//  link_clear    out  1     one-cycle strobe: drop link
//  snoop_busy    out  1     stall dcache FSM: ccwait | state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; latched addr/way/data=0; every output 0; probe_idx=0.
//  probe_idx = ccsnoopaddr idx in IDLE, latched idx otherwise.
//  hit[w] = frm_valid[w] & (frm_tag[w] == snoop tag).
//  IDLE, ccwait=0:
//   all strobes 0; ccinv is ignored.
//  IDLE, ccwait=1:
//   cctrans = hit & dirty, combinational in the same cycle; the controller samples it in its SNOOP cycle.
//   dirty hit: latch addr, way and both data words; go to WB0.
//   clean hit & ccinv: upd_en=1, valid=0, dirty=0 in the same cycle; stay in IDLE.
//   miss: no update, cctrans=0.
//  WB0:
//   cctrans=1; snp_daddr = {tag, idx, 3'b000}; snp_dstore = word0.
//   dwait=0 -> WB1; otherwise hold.
//  WB1:
//   cctrans=1; snp_daddr = {tag, idx, 3'b100}; snp_dstore = word1.
//   dwait=0 -> upd_en=1 on latched way; go to IDLE.
//   Sampled ccinv=1 in that cycle -> valid=0, dirty=0 (M->I); otherwise valid=1, dirty=0 (M->S).
//  Latency: a dirty snoop holds this agent for 2 + (dwait-high cycles) after the probe cycle.
//  Link: link_clear=1 in any cycle that asserts upd_en with valid=0 and link_valid & link_addr[31:3] == block addr.
//  ccwait dropping during WB0/WB1: ignored, writeback completes; the controller keeps driving dwait.
//  ccinv in WB0: ignored; only the WB1 completion cycle samples it.
//  Address: the latched address, not live ccsnoopaddr, drives WB0/WB1, so the controller may change ccsnoopaddr mid-writeback.
//  Reset mid-writeback: return to IDLE, no upd_en, frame keeps its M state.
//  snp_daddr/snp_dstore = 0 outside WB0/WB1.
// STRUCTURE
//  coherence_pkg:
//   snoop_state_t enum {IDLE, WB0, WB1}.
//   dcache_addr_t packed struct {tag, idx, blkoff, bytoff}.
//   IDX_W/TAG_W defaults and the BLK_WORDS=2 constant.
//  One sub-module snoop_way_match: valid/tag compare across WAYS -> hit vector, hit way, hit_dirty.
//  FSM and latch registers live in dcache_snoop_agent.
// TESTING
//  1 Reset mid-WB0 (nRST low one cycle) -> state IDLE, cctrans=0, no upd_en, frame still dirty.
//  2 Dirty hit: way1 tag match addr 0x0000_1248, data {0xBEEF0001, 0xBEEF0002}, ccwait=1 -> cctrans=1 that cycle.
//    WB0: snp_daddr=0x1248, dstore=0xBEEF0001; dwait low after 3 cycles -> WB1.
//    WB1: snp_daddr=0x124C, dstore=0xBEEF0002; dwait=0 with ccinv=0 -> upd_en, way1, valid=1, dirty=0.
//  3 Same block, ccinv=1 on the WB1 completion cycle -> upd valid=0, dirty=0.
//    link_valid=1, link_addr=0x124C -> link_clear=1 in the same cycle.
//  4 Clean hit way0, addr 0x0000_0040, ccwait=1, ccinv=1 -> cctrans=0; upd_en same cycle, valid=0; snoop_busy deasserts next cycle.
//  5 Snoop miss (tags differ), ccinv=1 -> no upd_en, no link_clear, cctrans=0.
//    ccwait=0 with ccinv=1 -> no action.
//  6 ccwait falls in WB0, ccsnoopaddr changed to 0xFFFF_FFF0 -> writeback finishes to the latched 0x1248/0x124C.

Source files
------------

// File: rtl/dcache_snoop_agent_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_snoop_agent_pkg                                     |
// | Brief   : Shared coherence types for the dcache snoop responder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dcache_snoop_agent_pkg;

   localparam int IDX_W     = 3;
   localparam int TAG_W     = 26;
   localparam int BLK_WORDS = 2;
   localparam int WORD_W    = 32;
   localparam int BLK_W     = BLK_WORDS * WORD_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB0  = 2'd1,
      WB1  = 2'd2
   } snoop_state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic             blkoff;
      logic [1:0]       bytoff;
   } dcache_addr_t;

   // Word-aligned address of one word of the block holding a.
   function automatic logic [WORD_W-1:0] wb_word_addr(input dcache_addr_t a, input logic word_sel);
      return {a.tag, a.idx, word_sel, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_snoop_agent_way_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_snoop_agent_way_match                               |
// | Brief   : Valid/tag compare across ways; lowest matching way wins.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dcache_snoop_agent_way_match
   import dcache_snoop_agent_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [WAYS-1:0]       frm_valid,
   input  logic [WAYS-1:0]       frm_dirty,
   input  logic [WAYS*TAG_W-1:0] frm_tag,
   input  logic [TAG_W-1:0]      snoop_tag,
   output logic [WAYS-1:0]       hit,
   output logic [WAY_W-1:0]      hit_way,
   output logic                  hit_dirty
);

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_cmp
         assign hit[gi] = frm_valid[gi] & (frm_tag[gi*TAG_W +: TAG_W] == snoop_tag);
      end
   endgenerate

   // Descending scan so the lowest-numbered matching way is the one left standing.
   always_comb begin
      hit_way   = '0;
      hit_dirty = 1'b0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (hit[w]) begin
            hit_way   = WAY_W'(w);
            hit_dirty = frm_dirty[w];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_snoop_agent.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dcache_snoop_agent                                         |
// | Brief   : MSI snoop responder: probe, dirty-block writeback, M->S/I. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dcache_snoop_agent
   import dcache_snoop_agent_pkg::*;
#(
   parameter int WAYS = 2
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  ccwait,
   input  logic                  ccinv,
   input  logic [31:0]           ccsnoopaddr,
   input  logic                  dwait,
   output logic [IDX_W-1:0]      probe_idx,
   input  logic [WAYS-1:0]       frm_valid,
   input  logic [WAYS-1:0]       frm_dirty,
   input  logic [WAYS*TAG_W-1:0] frm_tag,
   input  logic [WAYS*BLK_W-1:0] frm_data,
   output logic                  upd_en,
   output logic                  upd_way,
   output logic                  upd_valid,
   output logic                  upd_dirty,
   output logic                  cctrans,
   output logic [31:0]           snp_daddr,
   output logic [31:0]           snp_dstore,
   input  logic                  link_valid,
   input  logic [31:0]           link_addr,
   output logic                  link_clear,
   output logic                  snoop_busy
);

   snoop_state_t r_state, w_next;
   dcache_addr_t r_addr;
   logic         r_way;
   logic [BLK_W-1:0] r_data;

   dcache_addr_t     w_snp;
   logic [WAYS-1:0]  w_hit;
   logic             w_hit_way;
   logic             w_hit_dirty;
   logic             w_latch;
   logic [28:0]      w_blk_addr;
   logic             w_unused;

   assign w_snp     = dcache_addr_t'(ccsnoopaddr);
   assign probe_idx = (r_state == IDLE) ? w_snp.idx : r_addr.idx;
   assign w_unused  = ^{link_addr[2:0], r_addr.blkoff, r_addr.bytoff};

   dcache_snoop_agent_way_match #(.WAYS(WAYS)) u_way_match (
      .frm_valid (frm_valid),
      .frm_dirty (frm_dirty),
      .frm_tag   (frm_tag),
      .snoop_tag (w_snp.tag),
      .hit       (w_hit),
      .hit_way   (w_hit_way),
      .hit_dirty (w_hit_dirty)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_way   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_addr <= w_snp;
            r_way  <= w_hit_way;
            r_data <= frm_data[int'(w_hit_way)*BLK_W +: BLK_W];
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_latch    = 1'b0;
      cctrans    = 1'b0;
      upd_en     = 1'b0;
      upd_way    = 1'b0;
      upd_valid  = 1'b0;
      upd_dirty  = 1'b0;
      snp_daddr  = '0;
      snp_dstore = '0;
      w_blk_addr = (r_state == IDLE) ? ccsnoopaddr[31:3] : {r_addr.tag, r_addr.idx};
      case (r_state)
         IDLE: begin
            if (ccwait && (|w_hit)) begin
               if (w_hit_dirty) begin
                  cctrans = 1'b1;
                  w_latch = 1'b1;
                  w_next  = WB0;
               end else if (ccinv) begin
                  upd_en  = 1'b1;
                  upd_way = w_hit_way;
               end
            end
         end
         WB0: begin
            cctrans    = 1'b1;
            snp_daddr  = wb_word_addr(r_addr, 1'b0);
            snp_dstore = r_data[WORD_W-1:0];
            if (!dwait) w_next = WB1;
         end
         WB1: begin
            cctrans    = 1'b1;
            snp_daddr  = wb_word_addr(r_addr, 1'b1);
            snp_dstore = r_data[BLK_W-1:WORD_W];
            // ccinv is only honoured here: it picks M->I over M->S.
            if (!dwait) begin
               upd_en    = 1'b1;
               upd_way   = r_way;
               upd_valid = ~ccinv;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
      link_clear = upd_en & ~upd_valid & link_valid & (link_addr[31:3] == w_blk_addr);
      snoop_busy = ccwait | (r_state != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_snoop_agent.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dcache_snoop_agent                                      |
// | Brief   : Scoreboard bench for the dcache snoop responder.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dcache_snoop_agent;
   import dcache_snoop_agent_pkg::*;

   logic                CLK;
   logic                nRST;
   logic                ccwait, ccinv, dwait;
   logic [31:0]         ccsnoopaddr;
   logic [IDX_W-1:0]    probe_idx;
   logic [1:0]          frm_valid, frm_dirty;
   logic [2*TAG_W-1:0]  frm_tag;
   logic [2*BLK_W-1:0]  frm_data;
   logic                upd_en, upd_way, upd_valid, upd_dirty;
   logic                cctrans;
   logic [31:0]         snp_daddr, snp_dstore;
   logic                link_valid;
   logic [31:0]         link_addr;
   logic                link_clear, snoop_busy;

   dcache_snoop_agent #(.WAYS(2)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ccwait      (ccwait),
      .ccinv       (ccinv),
      .ccsnoopaddr (ccsnoopaddr),
      .dwait       (dwait),
      .probe_idx   (probe_idx),
      .frm_valid   (frm_valid),
      .frm_dirty   (frm_dirty),
      .frm_tag     (frm_tag),
      .frm_data    (frm_data),
      .upd_en      (upd_en),
      .upd_way     (upd_way),
      .upd_valid   (upd_valid),
      .upd_dirty   (upd_dirty),
      .cctrans     (cctrans),
      .snp_daddr   (snp_daddr),
      .snp_dstore  (snp_dstore),
      .link_valid  (link_valid),
      .link_addr   (link_addr),
      .link_clear  (link_clear),
      .snoop_busy  (snoop_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Frame array model: 8 sets x 2 ways, updated by the agent's strobe.
   logic             fv   [8][2];
   logic             fd   [8][2];
   logic [TAG_W-1:0] ft   [8][2];
   logic [BLK_W-1:0] fdat [8][2];

   always_comb begin
      frm_valid = '0;
      frm_dirty = '0;
      frm_tag   = '0;
      frm_data  = '0;
      for (int w = 0; w < 2; w++) begin
         frm_valid[w]              = fv[probe_idx][w];
         frm_dirty[w]              = fd[probe_idx][w];
         frm_tag[w*TAG_W +: TAG_W] = ft[probe_idx][w];
         frm_data[w*BLK_W +: BLK_W] = fdat[probe_idx][w];
      end
   end

   always @(posedge CLK) begin
      if (upd_en) begin
         fv[probe_idx][upd_way] <= upd_valid;
         fd[probe_idx][upd_way] <= upd_dirty;
      end
   end

   typedef struct {
      int          kind;   // 0 = writeback word, 1 = frame update
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  c;      // {valid, dirty, link_clear}
   } ev_t;

   ev_t sb[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic push_word(input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      e.kind = 0; e.a = addr; e.b = data; e.c = 3'b000;
      sb.push_back(e);
   endtask

   task automatic push_upd(input logic way, input logic v, input logic d, input logic lc);
      ev_t e;
      e.kind = 1; e.a = {31'd0, way}; e.b = '0; e.c = {v, d, lc};
      sb.push_back(e);
   endtask

   // Monitor: every accepted writeback word and every frame update is matched in order.
   always @(negedge CLK) begin
      ev_t e;
      if (nRST) begin
         if (cctrans && !dwait && (snp_daddr != 32'd0 || snp_dstore != 32'd0)) begin
            if (sb.size() == 0) chk("unexpected_wb_word", {32'd0, snp_daddr}, 64'd0);
            else begin
               e = sb.pop_front();
               chk("wb_kind", 64'(e.kind), 64'd0);
               chk("wb_daddr", {32'd0, snp_daddr}, {32'd0, e.a});
               chk("wb_dstore", {32'd0, snp_dstore}, {32'd0, e.b});
            end
         end
         if (upd_en) begin
            if (sb.size() == 0) chk("unexpected_upd", {63'd0, upd_en}, 64'd0);
            else begin
               e = sb.pop_front();
               chk("upd_kind", 64'(e.kind), 64'd1);
               chk("upd_way", {63'd0, upd_way}, {32'd0, e.a});
               chk("upd_state", {61'd0, upd_valid, upd_dirty, link_clear}, {61'd0, e.c});
            end
         end else if (link_clear) begin
            chk("spurious_link_clear", {63'd0, link_clear}, 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 2; w++) begin
            fv[s][w]   <= 1'b0;
            fd[s][w]   <= 1'b0;
            ft[s][w]   <= '0;
            fdat[s][w] <= '0;
         end
      end
      // set 1 way 1: M block at 0x1248
      fv[1][1] <= 1'b1; fd[1][1] <= 1'b1; ft[1][1] <= 26'h49;
      fdat[1][1] <= {32'hBEEF0002, 32'hBEEF0001};
      // set 0 way 0: S block at 0x40
      fv[0][0] <= 1'b1; ft[0][0] <= 26'h1;
      // set 2: valid tags that never match 0x90
      fv[2][0] <= 1'b1; ft[2][0] <= 26'h5;
      fv[2][1] <= 1'b1; ft[2][1] <= 26'h6;

      nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b0;
      ccsnoopaddr = 32'd0; link_valid = 1'b0; link_addr = 32'd0;

      mid();
      chk("rst_cctrans", {63'd0, cctrans}, 64'd0);
      chk("rst_upd_en", {63'd0, upd_en}, 64'd0);
      chk("rst_busy", {63'd0, snoop_busy}, 64'd0);
      chk("rst_probe_idx", {61'd0, probe_idx}, 64'd0);
      chk("rst_daddr", {32'd0, snp_daddr}, 64'd0);
      step();
      nRST = 1'b1;
      step();

      // Test 1: reset in the middle of WB0
      ccwait = 1'b1; ccsnoopaddr = 32'h0000_1248; dwait = 1'b1;
      mid();
      chk("t1_probe_cctrans", {63'd0, cctrans}, 64'd1);
      step();
      ccwait = 1'b0;
      mid();
      chk("t1_wb0_daddr", {32'd0, snp_daddr}, 64'h1248);
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      mid();
      chk("t1_cctrans", {63'd0, cctrans}, 64'd0);
      chk("t1_busy", {63'd0, snoop_busy}, 64'd0);
      chk("t1_daddr", {32'd0, snp_daddr}, 64'd0);
      chk("t1_frame_dirty", {62'd0, fv[1][1], fd[1][1]}, 64'd3);
      step();

      // Test 2: dirty hit, 3 dwait cycles in WB0, downgrade M->S
      ccwait = 1'b1; ccsnoopaddr = 32'h0000_1248; dwait = 1'b1; ccinv = 1'b0;
      push_word(32'h1248, 32'hBEEF0001);
      push_word(32'h124C, 32'hBEEF0002);
      push_upd(1'b1, 1'b1, 1'b0, 1'b0);
      mid();
      chk("t2_probe_cctrans", {63'd0, cctrans}, 64'd1);
      chk("t2_probe_busy", {63'd0, snoop_busy}, 64'd1);
      step();
      mid();
      chk("t2_wb0_dstore", {32'd0, snp_dstore}, 64'hBEEF0001);
      repeat (2) step();
      step();
      dwait = 1'b0;
      mid();
      chk("t2_wb0_cctrans", {63'd0, cctrans}, 64'd1);
      step();
      mid();
      chk("t2_wb1_daddr", {32'd0, snp_daddr}, 64'h124C);
      step();
      ccwait = 1'b0;
      mid();
      chk("t2_idle_busy", {63'd0, snoop_busy}, 64'd0);
      chk("t2_frame_S", {62'd0, fv[1][1], fd[1][1]}, 64'd2);

      // Test 3: same block redirtied, ccinv at WB1 completion, link dropped
      fd[1][1] <= 1'b1;
      step();
      ccwait = 1'b1; ccsnoopaddr = 32'h0000_1248; dwait = 1'b0;
      link_valid = 1'b1; link_addr = 32'h0000_124C;
      push_word(32'h1248, 32'hBEEF0001);
      push_word(32'h124C, 32'hBEEF0002);
      push_upd(1'b1, 1'b0, 1'b0, 1'b1);
      mid();
      chk("t3_probe_cctrans", {63'd0, cctrans}, 64'd1);
      step();
      ccinv = 1'b1;
      step();
      step();
      ccwait = 1'b0; ccinv = 1'b0;
      mid();
      chk("t3_frame_I", {62'd0, fv[1][1], fd[1][1]}, 64'd0);

      // Test 4: clean hit way 0 with ccinv; link at another block stays
      step();
      ccwait = 1'b1; ccinv = 1'b1; ccsnoopaddr = 32'h0000_0040;
      push_upd(1'b0, 1'b0, 1'b0, 1'b0);
      mid();
      chk("t4_cctrans", {63'd0, cctrans}, 64'd0);
      chk("t4_busy", {63'd0, snoop_busy}, 64'd1);
      step();
      ccwait = 1'b0; ccinv = 1'b0;
      mid();
      chk("t4_busy_after", {63'd0, snoop_busy}, 64'd0);
      chk("t4_frame_I", {63'd0, fv[0][0]}, 64'd0);

      // Test 5: miss with ccinv, then ccinv without ccwait
      fv[0][0] <= 1'b1;
      step();
      ccwait = 1'b1; ccinv = 1'b1; ccsnoopaddr = 32'h0000_0090;
      mid();
      chk("t5_miss_cctrans", {63'd0, cctrans}, 64'd0);
      chk("t5_miss_upd", {63'd0, upd_en}, 64'd0);
      step();
      ccwait = 1'b0; ccsnoopaddr = 32'h0000_0040;
      mid();
      chk("t5_nowait_upd", {63'd0, upd_en}, 64'd0);
      step();
      ccinv = 1'b0;
      mid();
      chk("t5_frame_kept", {63'd0, fv[0][0]}, 64'd1);

      // Test 6: ccwait drops and address moves mid-writeback
      fv[1][1] <= 1'b1; fd[1][1] <= 1'b1;
      link_valid = 1'b0;
      step();
      ccwait = 1'b1; ccsnoopaddr = 32'h0000_1248; dwait = 1'b1;
      push_word(32'h1248, 32'hBEEF0001);
      push_word(32'h124C, 32'hBEEF0002);
      push_upd(1'b1, 1'b1, 1'b0, 1'b0);
      mid();
      chk("t6_probe_cctrans", {63'd0, cctrans}, 64'd1);
      step();
      ccwait = 1'b0; ccsnoopaddr = 32'hFFFF_FFF0;
      mid();
      chk("t6_wb0_daddr", {32'd0, snp_daddr}, 64'h1248);
      chk("t6_probe_idx", {61'd0, probe_idx}, 64'd1);
      step();
      dwait = 1'b0;
      step();
      step();
      mid();
      chk("t6_frame_S", {62'd0, fv[1][1], fd[1][1]}, 64'd2);

      repeat (3) step();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
